control_unit: RTL and testbench
===============================

# control_unit

Decode-stage control block for the RV32I processor. It decodes the 32-bit instruction from fetch and holds the 32×32 integer register file. Each cycle it presents a registered ALU opcode, two ALU operands and data-memory controls to execute. It writes the execute/memory result (`write_data`) back into the register file.

## Interface
Parameters: none. Widths are fixed by RV32I.

- `clk_i` in 1: single clock. All state updates on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `instruction_i` in 32: instruction word to decode.
- `write_data` in 32: write-back value for the destination register of the instruction currently held in the output stage.
- `aluControl_o` out 4: ALU operation code.
- `op1` out 32: ALU operand A.
- `op2` out 32: ALU operand B.
- `mem_en` out 1: data-memory access this cycle.
- `mem_wr` out 1: 1 = store, 0 = load; valid only when `mem_en`=1.
- `mem_addr` out 32: effective address, rs1 + sign-extended immediate.

## Operation
- Supported opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, LUI 0110111. Any other opcode decodes as a NOP: ADD, op1=op2=0, `mem_en`=0, no write-back.
- ALU codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - 11–15 are unused and never driven.
- OP: code from funct3 plus funct7[5]. funct7[5]=1 selects SUB (funct3=000) or SRA (funct3=101). op1=x[rs1], op2=x[rs2].
- OP-IMM: code from funct3. funct7[5] selects SRAI only; ADDI never maps to SUB. op1=x[rs1], op2=sign-extended I-immediate. Shift immediates use imm[4:0], zero-extended.
- LOAD: ADD. op1=x[rs1], op2=I-immediate. `mem_en`=1, `mem_wr`=0, `mem_addr`=x[rs1]+I-imm.
- STORE: ADD. op1=x[rs1], op2=x[rs2] (store data). `mem_en`=1, `mem_wr`=1, `mem_addr`=x[rs1]+S-imm.
- LUI: PASSB. op1=0, op2={imm[31:12],12'b0}.
- Register file:
  - 32×32; x0 reads 0 and ignores writes.
  - Two combinational read ports, one synchronous write port.
- Write-back:
  - Happens on the edge that ends the cycle in which the instruction is in the output stage.
  - Target is the registered rd.
  - Applies only if the registered instruction is OP, OP-IMM, LOAD or LUI and rd≠0.
- Address arithmetic is modulo 2^32. Overflow is ignored.

## Timing
- Latency 1 cycle: `instruction_i` sampled at edge N appears decoded on all outputs after edge N. No handshake; a new instruction is accepted every cycle.
- Operand read takes place at the sampling edge, combinationally from the register file.
- Write at edge N and read of the same register at edge N: the read returns the old value unless `CONTROL_UNIT_FWD_EN` is defined.
- Reset:
  - Clears all 32 registers and the output stage: `aluControl_o`=0, op1=0, op2=0, `mem_en`=0, `mem_wr`=0, `mem_addr`=0, and the registered write-back enable=0.
  - Reset dominates both write-back and instruction sampling in the same cycle.
  - Mid-operation reset discards the in-flight instruction; its write-back does not occur.
- X or undefined `instruction_i` while in reset has no effect.

## Configuration
- `CONTROL_UNIT_FWD_EN` defined: if a write-back at edge N targets rs1 or rs2 (≠x0) of the instruction sampled at edge N, `write_data` is forwarded into op1/op2/`mem_addr`. The register-file value is not used in that case.
- `CONTROL_UNIT_FWD_EN` undefined: no bypass. The old register value is used.

## Structure
- Shared package `rv32i_pkg`:
  - Opcode constants.
  - `alu_op_t` enum (4-bit, codes above).
  - funct3 constants.
  - Immediate-extract functions: I, S, U.
- One sub-module, `reg_file`: 32×32, two async reads, one sync write, synchronous clear, x0 hardwired to zero.
- Decode and output register live in the top level.

## Test plan
1. Reset held 1 cycle, then `instruction_i`=0x02258513 (addi a0,a1,34) → after next edge: `aluControl_o`=0, op1=0, op2=34, `mem_en`=0.
2. Same cycle `write_data`=0x55 → x10=0x55. Then 0x40a50533 (sub a0,a0,a0) → `aluControl_o`=1, op1=op2=0x55.
3. 0x40c58533 (sub a0,a1,a2) after x11=7 and x12=3 have been written → `aluControl_o`=1, op1=7, op2=3.
4. Store 0x00b52223 (sw a1,4(a0)) with x10=0x100 and x11=9 → `mem_en`=1, `mem_wr`=1, `mem_addr`=0x104, op2=9. Load 0x00452583 (lw a1,4(a0)) → `mem_en`=1, `mem_wr`=0, `mem_addr`=0x104.
5. Write to x0: addi x0,x0,5 with `write_data`=0xFFFF → later read of x0 gives 0. Reset asserted mid-stream → all outputs 0 next cycle and all registers read 0.
6. `CONTROL_UNIT_FWD_EN`: addi a0,… followed immediately by sub a1,a0,a0 with `write_data`=0x20 → op1=op2=0x20 when defined, 0 when undefined.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions for the control_unit slice.
// Provides the opcode and funct3 constants, the 4-bit ALU operation enum,
// the I/S/U immediate extractors and the funct3-to-ALU-op mapping shared by
// the register and immediate arithmetic forms.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  // funct7[5] (instr[30]) only picks SUB for the register form; the immediate
  // form has no SUBI, so ADDI with that bit set still decodes as ADD.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                         input logic       alt,
                                         input logic       is_reg);
    alu_op_t op;
    case (funct3)
      F3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file.
// Ports:
//   clk_i, reset_i      : clock and synchronous active-high clear of all entries
//   rs1_addr_i/rs2_addr_i: asynchronous read addresses
//   rs1_data_o/rs2_data_o: read data, x0 always returns zero
//   we_i, waddr_i, wdata_i: synchronous write port, writes to x0 are dropped
module reg_file (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Clear takes priority over any write presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/control_unit.sv
// RV32I decode-stage control unit.
// Decodes instruction_i against the register file and registers the ALU
// opcode, operands and data-memory controls for execute (1-cycle latency).
// write_data is written back to the registered rd of the instruction held in
// the output stage at the end of that cycle.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   instruction_i  : instruction word to decode
//   write_data     : write-back value for the output-stage instruction
//   aluControl_o   : ALU operation (alu_op_t encoding)
//   op1, op2       : ALU operands
//   mem_en, mem_wr : data-memory access / store(1) vs load(0)
//   mem_addr       : rs1 + sign-extended immediate for loads and stores
// Build option: define CONTROL_UNIT_FWD_EN to bypass a same-edge write-back
// into the operand read of the instruction being sampled.
module control_unit
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] write_data,
  output logic [3:0]  aluControl_o,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  alu_op_t     alu_d, alu_q;
  logic [31:0] op1_d, op1_q;
  logic [31:0] op2_d, op2_q;
  logic        mem_en_d, mem_en_q;
  logic        mem_wr_d, mem_wr_q;
  logic [31:0] mem_addr_d, mem_addr_q;
  logic        wb_en_d, wb_en_q;
  logic [4:0]  rd_d, rd_q;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign alt    = instruction_i[30];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];
  assign rd     = instruction_i[11:7];

  reg_file u_reg_file (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rs1_data_o (rf_rs1),
    .rs2_data_o (rf_rs2),
    .we_i       (wb_en_q),
    .waddr_i    (rd_q),
    .wdata_i    (write_data)
  );

`ifdef CONTROL_UNIT_FWD_EN
  // The write-back landing on this edge is not yet visible in the register
  // file, so steer write_data straight into the matching operand. wb_en_q is
  // only ever set for rd != x0, but rs != 0 is kept explicit for clarity.
  always_comb begin
    rs1_val = rf_rs1;
    rs2_val = rf_rs2;
    if (wb_en_q && (rs1 != 5'd0) && (rd_q == rs1)) begin
      rs1_val = write_data;
    end
    if (wb_en_q && (rs2 != 5'd0) && (rd_q == rs2)) begin
      rs2_val = write_data;
    end
  end
`else
  always_comb begin
    rs1_val = rf_rs1;
    rs2_val = rf_rs2;
  end
`endif

  // Unknown opcodes fall through with the defaults, which form the NOP.
  always_comb begin
    alu_d      = ALU_ADD;
    op1_d      = '0;
    op2_d      = '0;
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = '0;
    wb_en_d    = 1'b0;
    rd_d       = rd;
    case (opcode)
      OPC_OP: begin
        alu_d   = alu_decode(funct3, alt, 1'b1);
        op1_d   = rs1_val;
        op2_d   = rs2_val;
        wb_en_d = (rd != 5'd0);
      end
      OPC_OP_IMM: begin
        alu_d = alu_decode(funct3, alt, 1'b0);
        op1_d = rs1_val;
        // Shift amounts are the low five immediate bits, never sign-extended.
        if ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) begin
          op2_d = {27'b0, instruction_i[24:20]};
        end else begin
          op2_d = imm_i(instruction_i);
        end
        wb_en_d = (rd != 5'd0);
      end
      OPC_LOAD: begin
        op1_d      = rs1_val;
        op2_d      = imm_i(instruction_i);
        mem_en_d   = 1'b1;
        mem_addr_d = rs1_val + imm_i(instruction_i);
        wb_en_d    = (rd != 5'd0);
      end
      OPC_STORE: begin
        op1_d      = rs1_val;
        op2_d      = rs2_val;
        mem_en_d   = 1'b1;
        mem_wr_d   = 1'b1;
        mem_addr_d = rs1_val + imm_s(instruction_i);
      end
      OPC_LUI: begin
        alu_d   = ALU_PASSB;
        op2_d   = imm_u(instruction_i);
        wb_en_d = (rd != 5'd0);
      end
      default: begin
      end
    endcase
  end

  // Reset discards whatever was sampled, including a pending write-back.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alu_q      <= ALU_ADD;
      op1_q      <= '0;
      op2_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      wb_en_q    <= 1'b0;
      rd_q       <= '0;
    end else begin
      alu_q      <= alu_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      wb_en_q    <= wb_en_d;
      rd_q       <= rd_d;
    end
  end

  assign aluControl_o = alu_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a randomized
// instruction stream compared against a behavioural architectural model.
module tb_control_unit;

  logic        clk;
  logic        reset_i;
  logic [31:0] instruction_i;
  logic [31:0] write_data;
  logic [3:0]  aluControl_o;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;

  int total = 0;
  int bad   = 0;

  // architectural model state
  logic [31:0] mregs [32];
  logic        pend_wb;
  logic [4:0]  pend_rd;
  logic [3:0]  exp_alu;
  logic [31:0] exp_op1, exp_op2, exp_addr;
  logic        exp_en, exp_wr;

`ifdef CONTROL_UNIT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  control_unit dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .instruction_i(instruction_i),
    .write_data   (write_data),
    .aluControl_o (aluControl_o),
    .op1          (op1),
    .op2          (op2),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one clock edge: decode from architectural registers (plus a
  // same-edge bypass when enabled), then retire the pending write-back.
  task automatic model_cycle(input logic [31:0] ins, input logic [31:0] wd, input logic rst);
    int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] a, b, d;
    logic alt, nwb;
    logic signed [11:0] ii, si;
    int ti, ts;
    logic [31:0] r1, r2;
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      pend_wb = 1'b0; pend_rd = 5'd0;
      exp_alu = 4'd0; exp_op1 = 32'd0; exp_op2 = 32'd0;
      exp_en = 1'b0; exp_wr = 1'b0; exp_addr = 32'd0;
      return;
    end
    opc = ins[6:0]; f3 = ins[14:12]; alt = ins[30];
    a = ins[19:15]; b = ins[24:20]; d = ins[11:7];
    ii = ins[31:20]; si = {ins[31:25], ins[11:7]};
    ti = ii; ts = si;
    r1 = mregs[a]; r2 = mregs[b];
    if (FWD && pend_wb && a != 0 && pend_rd == a) r1 = wd;
    if (FWD && pend_wb && b != 0 && pend_rd == b) r2 = wd;
    exp_alu = 4'd0; exp_op1 = 32'd0; exp_op2 = 32'd0;
    exp_en = 1'b0; exp_wr = 1'b0; exp_addr = 32'd0; nwb = 1'b0;
    case (opc)
      7'h33: begin
        exp_alu = 4'(base[f3] + ((alt && (f3 == 0 || f3 == 5)) ? 1 : 0));
        exp_op1 = r1; exp_op2 = r2; nwb = 1'b1;
      end
      7'h13: begin
        exp_alu = 4'(base[f3] + ((alt && f3 == 5) ? 1 : 0));
        exp_op1 = r1;
        exp_op2 = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : ti;
        nwb = 1'b1;
      end
      7'h03: begin
        exp_op1 = r1; exp_op2 = ti; exp_en = 1'b1; exp_addr = r1 + ti; nwb = 1'b1;
      end
      7'h23: begin
        exp_op1 = r1; exp_op2 = r2; exp_en = 1'b1; exp_wr = 1'b1; exp_addr = r1 + ts;
      end
      7'h37: begin
        exp_alu = 4'd10; exp_op2 = ins & 32'hFFFF_F000; nwb = 1'b1;
      end
      default: ;
    endcase
    if (pend_wb && pend_rd != 0) mregs[pend_rd] = wd;
    pend_wb = nwb && (d != 0);
    pend_rd = d;
  endtask

  // One cycle: drive at the falling edge, DUT samples at the rising edge,
  // outputs observed 1 ns later.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] wd, input logic rst);
    @(negedge clk);
    instruction_i = ins;
    write_data    = wd;
    reset_i       = rst;
    model_cycle(ins, wd, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'b1);
    applyStimulus(32'hxxxx_xxxx, 32'h0000_FFFF, 1'b1);
    total++; if (aluControl_o !== 4'd0) begin bad++; $display("[TB] FAIL reset_alu got=%0d want=0", aluControl_o); end
    total++; if (op1 !== 32'd0) begin bad++; $display("[TB] FAIL reset_op1 got=%h want=0", op1); end
    total++; if (op2 !== 32'd0) begin bad++; $display("[TB] FAIL reset_op2 got=%h want=0", op2); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en got=%b want=0", mem_en); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_wr got=%b want=0", mem_wr); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h want=0", mem_addr); end
  endtask

  task automatic test_directed();
    // addi a0,a1,34
    applyStimulus(32'h0225_8513, 32'd0, 1'b0);
    total++; if (aluControl_o !== 4'd0) begin bad++; $display("[TB] FAIL addi_alu got=%0d want=0", aluControl_o); end
    total++; if (op1 !== 32'd0) begin bad++; $display("[TB] FAIL addi_op1 got=%h want=0", op1); end
    total++; if (op2 !== 32'd34) begin bad++; $display("[TB] FAIL addi_op2 got=%h want=22", op2); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL addi_mem_en got=%b want=0", mem_en); end
    // write-back x10=0x55 under a NOP, then sub a0,a0,a0
    applyStimulus(32'h0000_0000, 32'h55, 1'b0);
    applyStimulus(32'h40a5_0533, 32'd0, 1'b0);
    total++; if (aluControl_o !== 4'd1) begin bad++; $display("[TB] FAIL sub_aa_alu got=%0d want=1", aluControl_o); end
    total++; if (op1 !== 32'h55 || op2 !== 32'h55) begin bad++; $display("[TB] FAIL sub_aa_ops got=%h,%h want=55,55", op1, op2); end
    // x11=7, x12=3, then sub a0,a1,a2 (its write-back puts 0x100 in x10)
    applyStimulus(32'h0070_0593, 32'd0, 1'b0);
    applyStimulus(32'h0030_0613, 32'd7, 1'b0);
    applyStimulus(32'h0000_0000, 32'd3, 1'b0);
    applyStimulus(32'h40c5_8533, 32'd0, 1'b0);
    total++; if (aluControl_o !== 4'd1) begin bad++; $display("[TB] FAIL sub_alu got=%0d want=1", aluControl_o); end
    total++; if (op1 !== 32'd7) begin bad++; $display("[TB] FAIL sub_op1 got=%h want=7", op1); end
    total++; if (op2 !== 32'd3) begin bad++; $display("[TB] FAIL sub_op2 got=%h want=3", op2); end
    applyStimulus(32'h0090_0593, 32'h100, 1'b0);
    applyStimulus(32'h0000_0000, 32'd9, 1'b0);
    // sw a1,4(a0)
    applyStimulus(32'h00b5_2223, 32'd0, 1'b0);
    total++; if (mem_en !== 1'b1 || mem_wr !== 1'b1) begin bad++; $display("[TB] FAIL sw_ctrl got=%b%b want=11", mem_en, mem_wr); end
    total++; if (mem_addr !== 32'h104) begin bad++; $display("[TB] FAIL sw_addr got=%h want=104", mem_addr); end
    total++; if (op2 !== 32'd9) begin bad++; $display("[TB] FAIL sw_data got=%h want=9", op2); end
    // lw a1,4(a0)
    applyStimulus(32'h0045_2583, 32'd0, 1'b0);
    total++; if (mem_en !== 1'b1 || mem_wr !== 1'b0) begin bad++; $display("[TB] FAIL lw_ctrl got=%b%b want=10", mem_en, mem_wr); end
    total++; if (mem_addr !== 32'h104) begin bad++; $display("[TB] FAIL lw_addr got=%h want=104", mem_addr); end
    // lui x5,0xABCDE
    applyStimulus(32'hABCD_E2B7, 32'd0, 1'b0);
    total++; if (aluControl_o !== 4'd10) begin bad++; $display("[TB] FAIL lui_alu got=%0d want=10", aluControl_o); end
    total++; if (op1 !== 32'd0 || op2 !== 32'hABCD_E000) begin bad++; $display("[TB] FAIL lui_ops got=%h,%h want=0,abcde000", op1, op2); end
    // addi x0,x0,5 with write_data=0xFFFF, then read x0 twice
    applyStimulus(32'h0050_0013, 32'd0, 1'b0);
    applyStimulus(32'h0000_02b3, 32'h0000_FFFF, 1'b0);
    total++; if (op1 !== 32'd0 || op2 !== 32'd0) begin bad++; $display("[TB] FAIL x0_read1 got=%h,%h want=0,0", op1, op2); end
    applyStimulus(32'h0000_0333, 32'd0, 1'b0);
    total++; if (op1 !== 32'd0 || op2 !== 32'd0) begin bad++; $display("[TB] FAIL x0_read2 got=%h,%h want=0,0", op1, op2); end
  endtask

  task automatic test_midreset();
    logic [4:0]  ra, rb;
    logic [31:0] ins;
    // fill x1..x30 with 0x1000+i+1, x31 via the read below
    for (int i = 1; i < 32; i++) begin
      ins = {12'd0, 5'd0, 3'b000, 5'(i), 7'h13};
      applyStimulus(ins, 32'h1000 + i, 1'b0);
    end
    applyStimulus(32'h01e0_82b3, 32'h2000, 1'b0);  // add x5,x1,x30
    total++; if (op1 !== 32'h1002 || op2 !== 32'h101F) begin bad++; $display("[TB] FAIL fill_read got=%h,%h want=1002,101f", op1, op2); end
    applyStimulus(32'h0050_0113, 32'hBEEF, 1'b1);  // addi x2 sampled under reset
    total++; if (aluControl_o !== 4'd0 || op1 !== 32'd0 || op2 !== 32'd0) begin bad++; $display("[TB] FAIL midreset_alu_ops got=%0d,%h,%h want=0,0,0", aluControl_o, op1, op2); end
    total++; if (mem_en !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'd0) begin bad++; $display("[TB] FAIL midreset_mem got=%b,%b,%h want=0,0,0", mem_en, mem_wr, mem_addr); end
    applyStimulus(32'h0000_0000, 32'h1234, 1'b0);
    for (int k = 0; k < 16; k++) begin
      ra = 5'(2 * k + 1);
      rb = 5'(2 * k + 2);
      ins = {7'd0, rb, ra, 3'b000, 5'd0, 7'h33};
      applyStimulus(ins, 32'h5A5A_0000 + k, 1'b0);
      total++; if (op1 !== 32'd0 || op2 !== 32'd0) begin bad++; $display("[TB] FAIL cleared_x%0d_x%0d got=%h,%h want=0,0", ra, rb, op1, op2); end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] want;
    want = FWD ? 32'h20 : 32'h0;
    applyStimulus(32'h0010_0513, 32'd0, 1'b0);   // addi a0,x0,1
    applyStimulus(32'h40a5_05b3, 32'h20, 1'b0);  // sub a1,a0,a0
    total++; if (aluControl_o !== 4'd1) begin bad++; $display("[TB] FAIL fwd_alu got=%0d want=1", aluControl_o); end
    total++; if (op1 !== want || op2 !== want) begin bad++; $display("[TB] FAIL fwd_ops got=%h,%h want=%h,%h", op1, op2, want, want); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] u;
    logic [6:0]  opc;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom); imm = 12'($urandom); u = $urandom;
    case ($urandom_range(0, 5))
      0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
      1: return {imm, rs1, f3, rd, 7'h13};
      2: return {imm, rs1, 3'b010, rd, 7'h03};
      3: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      4: return {u[19:0], rd, 7'h37};
      default: begin
        do opc = 7'($urandom);
        while (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 || opc == 7'h37);
        return {u[24:0], opc};
      end
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      ins = rand_instr();
      applyStimulus(ins, $urandom, 1'b0);
      total++; if (aluControl_o !== exp_alu) begin bad++; $display("[TB] FAIL rand_alu[%0d] ins=%h got=%0d want=%0d", n, ins, aluControl_o, exp_alu); end
      total++; if (op1 !== exp_op1) begin bad++; $display("[TB] FAIL rand_op1[%0d] ins=%h got=%h want=%h", n, ins, op1, exp_op1); end
      total++; if (op2 !== exp_op2) begin bad++; $display("[TB] FAIL rand_op2[%0d] ins=%h got=%h want=%h", n, ins, op2, exp_op2); end
      total++; if (mem_en !== exp_en) begin bad++; $display("[TB] FAIL rand_mem_en[%0d] ins=%h got=%b want=%b", n, ins, mem_en, exp_en); end
      if (exp_en) begin
        total++; if (mem_wr !== exp_wr) begin bad++; $display("[TB] FAIL rand_mem_wr[%0d] ins=%h got=%b want=%b", n, ins, mem_wr, exp_wr); end
        total++; if (mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL rand_mem_addr[%0d] ins=%h got=%h want=%h", n, ins, mem_addr, exp_addr); end
      end
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    instruction_i = 32'd0;
    write_data    = 32'd0;
    test_reset();
    test_directed();
    test_midreset();
    test_forwarding();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
